// File: rtl/router_pkg.sv
// Shared definitions for the router read-side channel: default widths,
// header field layout, pointer sizing helper and the tagged FIFO entry.
package router_pkg;

  // Default flit width used when an instance does not override DATA_W.
  localparam int DEF_DATA_W = 8;

  // The header length field occupies data[DATA_W-1:HDR_LEN_LSB].
  localparam int HDR_LEN_LSB = 2;

  // Pointer width for a power-of-two FIFO: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // One FIFO entry: header tag plus data.
  typedef struct packed {
    logic                  hdr;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_fifo_core.sv
// Tagged FIFO storage for one router output channel. Wrap-bit pointers
// give exact full/empty; flush returns both pointers to zero and
// suppresses any write presented in the same cycle.
module router_fifo_core
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic              wr_hdr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              flush,
  output logic              rd_hdr,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  // Storage is not reset so it can map onto RAM primitives.
  logic [DATA_W:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wr_go;
  logic             rd_go;

  // Equal pointers mean empty; equal addresses with differing wrap bits mean full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  // Full/empty come from registered pointers, so a read while full does
  // not make room for a write in the same cycle.
  assign wr_go = wr_en && !full && !flush;
  assign rd_go = rd_en && !empty && !flush;

  // Entry presented at the read pointer; the channel registers it.
  assign {rd_hdr, rd_data} = mem[rd_ptr_q[ADDR_W-1:0]];

  // Next-state pointer arithmetic; flush takes priority over traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_go) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_go) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clock) begin
    if (wr_go) mem[wr_ptr_q[ADDR_W-1:0]] <= {wr_hdr, wr_data};
  end

endmodule

// File: rtl/router_rd_chan.sv
// Read-side output channel: FIFO core plus registered read data, a
// packet-boundary tracker and a stall timeout that flushes the channel.
module router_rd_chan
  import router_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              vld_out,
  output logic              full,
  output logic              empty,
  output logic              pkt_active,
  output logic              overflow,
  output logic              soft_rst
);

  localparam int LEN_W   = DATA_W - HDR_LEN_LSB;
  localparam int REM_W   = LEN_W + 1;
  localparam int SC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic              fifo_full;
  logic              fifo_empty;
  logic              rd_hdr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_accept;
  logic              stall;
  logic              flush;

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              pkt_active_q, pkt_active_d;
  logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic              overflow_q, overflow_d;
  logic              soft_rst_q, soft_rst_d;

  router_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (write_enb),
    .wr_hdr  (lfd_state),
    .wr_data (data_in),
    .rd_en   (read_enb),
    .flush   (flush),
    .rd_hdr  (rd_hdr),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_accept = read_enb && !fifo_empty;
  assign stall     = !fifo_empty && !read_enb;
  // Flush on the edge that would complete TIMEOUT consecutive stalled cycles.
  assign flush     = (TIMEOUT > 0) && stall && (stall_cnt_q == SC_W'(TO_LAST));

  // Read data register: loads on an accepted read, cleared by a flush.
  always_comb begin
    data_out_d = data_out_q;
    if (flush) begin
      data_out_d = '0;
    end else if (rd_accept) begin
      data_out_d = rd_data;
    end
  end

  // Packet tracker: a header loads length+1 (payload plus parity), later
  // reads count down; a header seen mid-packet restarts the count.
  always_comb begin
    rem_d        = rem_q;
    pkt_active_d = pkt_active_q;
    if (flush) begin
      rem_d        = '0;
      pkt_active_d = 1'b0;
    end else if (rd_accept) begin
      if (rd_hdr) begin
        rem_d        = REM_W'(rd_data[DATA_W-1:HDR_LEN_LSB]) + REM_W'(1);
        pkt_active_d = 1'b1;
      end else if (pkt_active_q) begin
        rem_d = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) pkt_active_d = 1'b0;
      end
    end
  end

  // Stall counter: counts cycles with data waiting and no read request.
  always_comb begin
    if ((TIMEOUT == 0) || flush || !stall) begin
      stall_cnt_d = '0;
    end else begin
      stall_cnt_d = stall_cnt_q + SC_W'(1);
    end
  end

  // Status pulses; a write lost to a flush is not reported as overflow.
  always_comb begin
    overflow_d = write_enb && fifo_full && !flush;
    soft_rst_d = flush;
  end

  // Channel state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out_q   <= '0;
      rem_q        <= '0;
      pkt_active_q <= 1'b0;
      stall_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      soft_rst_q   <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      rem_q        <= rem_d;
      pkt_active_q <= pkt_active_d;
      stall_cnt_q  <= stall_cnt_d;
      overflow_q   <= overflow_d;
      soft_rst_q   <= soft_rst_d;
    end
  end

  assign data_out   = data_out_q;
  assign vld_out    = !fifo_empty;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign pkt_active = pkt_active_q;
  assign overflow   = overflow_q;
  assign soft_rst   = soft_rst_q;

endmodule
